exc_unit: RTL

//   Parametrised exception/interrupt unit for the accumulator CPU. It replaces the fixed three-source vector logic.
//   - Sources: software interrupt, illegal instruction, and N_IRQ external lines.
//   - Adds edge-latched pending bits, per-line masks, a global interrupt enable and fixed priority.
//   - Adds a return-address/IE save on entry and a return-from-exception restore.
//   - Sits beside the PC register; the PC loads exc_new_pc_o whenever exc_take_o=1.

---
 rtl/exc_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/exc_unit.sv
// Exception/interrupt unit: edge-latched IRQs, masks, global IE, fixed priority, return save/restore.
// Optional nested save stack enabled by defining EXC_NEST_EN.
module exc_unit #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned N_IRQ      = 4,
    parameter int unsigned VEC_BASE   = 64,
    parameter int unsigned VEC_STRIDE = 8,
    parameter int unsigned NEST_DEPTH = 4
) (
    input  logic              exc_clk_i,
    input  logic              exc_rst_n_i,
    input  logic              exc_commit_i,
    input  logic              exc_int_ins_i,
    input  logic              exc_bad_ins_i,
    input  logic              exc_iret_i,
    input  logic [N_IRQ-1:0]  exc_irq_i,
    input  logic              exc_pc_sel_i,
    input  logic [ADDR_W-1:0] exc_pc_i,
    input  logic [ADDR_W-1:0] exc_jmp_addr_i,
    input  logic              exc_ie_we_i,
    input  logic              exc_ie_d_i,
    input  logic              exc_mask_we_i,
    input  logic [N_IRQ-1:0]  exc_mask_d_i,
    output logic              exc_take_o,
    output logic [ADDR_W-1:0] exc_new_pc_o,
    output logic [ADDR_W-1:0] exc_ret_addr_o,
    output logic [4:0]        exc_cause_o,
    output logic              exc_ie_o,
    output logic [N_IRQ-1:0]  exc_pending_o,
    output logic              exc_ovf_o
);

    localparam int unsigned CAUSE_W = 5;

    logic [N_IRQ-1:0]   irq_q;
    logic [N_IRQ-1:0]   pending_q;
    logic [N_IRQ-1:0]   mask_q;
    logic               ie_q;
    logic [N_IRQ-1:0]   irq_rise;
    logic [N_IRQ-1:0]   irq_act;
    logic               sync_c;
    logic               iret_c;
    logic               ret_pie_c;
    logic [CAUSE_W-1:0] cause_c;
    logic [N_IRQ-1:0]   irq_sel_c;
    logic [N_IRQ-1:0]   pend_clr_c;
    logic [ADDR_W-1:0]  ret_next;

    assign irq_rise     = exc_irq_i & ~irq_q;
    assign irq_act      = pending_q & mask_q;
    assign sync_c       = exc_int_ins_i | exc_bad_ins_i;
    assign exc_take_o   = exc_commit_i & (sync_c | (ie_q & (|irq_act) & ~exc_iret_i));
    assign iret_c       = exc_commit_i & exc_iret_i & ~sync_c;
    assign ret_next     = exc_pc_sel_i ? exc_jmp_addr_i : exc_pc_i + ADDR_W'(1);
    assign exc_new_pc_o = ADDR_W'(VEC_BASE + 32'(cause_c) * VEC_STRIDE);
    assign pend_clr_c   = (exc_take_o && !sync_c) ? irq_sel_c : '0;

    // Cause select: sync causes first, then lowest-index enabled pending line.
    always_comb begin
        cause_c   = '0;
        irq_sel_c = '0;
        if (exc_int_ins_i) begin
            cause_c = CAUSE_W'(0);
        end else if (exc_bad_ins_i) begin
            cause_c = CAUSE_W'(1);
        end else begin
            for (int k = int'(N_IRQ) - 1; k >= 0; k--) begin
                if (irq_act[k]) begin
                    cause_c      = CAUSE_W'(k + 2);
                    irq_sel_c    = '0;
                    irq_sel_c[k] = 1'b1;
                end
            end
        end
    end

    // Edge detect, pending latch (new edge beats clear) and mask register.
    always_ff @(posedge exc_clk_i or negedge exc_rst_n_i) begin
        if (!exc_rst_n_i) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            irq_q     <= exc_irq_i;
            pending_q <= (pending_q & ~pend_clr_c) | irq_rise;
            if (exc_mask_we_i) begin
                mask_q <= exc_mask_d_i;
            end
        end
    end

    // Global IE: take clears it, iret restores it, otherwise software write.
    always_ff @(posedge exc_clk_i or negedge exc_rst_n_i) begin
        if (!exc_rst_n_i) begin
            ie_q <= 1'b0;
        end else if (exc_take_o) begin
            ie_q <= 1'b0;
        end else if (iret_c) begin
            ie_q <= ret_pie_c;
        end else if (exc_ie_we_i) begin
            ie_q <= exc_ie_d_i;
        end
    end

`ifdef EXC_NEST_EN
    localparam int unsigned SP_W = $clog2(NEST_DEPTH + 1);

    logic [ADDR_W-1:0]  stk_ret   [NEST_DEPTH];
    logic [CAUSE_W-1:0] stk_cause [NEST_DEPTH];
    logic               stk_pie   [NEST_DEPTH];
    logic [SP_W-1:0]    sp_q;
    logic               ovf_q;

    assign ret_pie_c = (sp_q != '0) & stk_pie[0];

    // Entry 0 is the top; a push when full shifts the oldest entry out.
    always_ff @(posedge exc_clk_i or negedge exc_rst_n_i) begin
        if (!exc_rst_n_i) begin
            for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                stk_ret[i]   <= '0;
                stk_cause[i] <= '0;
                stk_pie[i]   <= 1'b0;
            end
            sp_q  <= '0;
            ovf_q <= 1'b0;
        end else if (exc_take_o) begin
            for (int i = int'(NEST_DEPTH) - 1; i > 0; i--) begin
                stk_ret[i]   <= stk_ret[i-1];
                stk_cause[i] <= stk_cause[i-1];
                stk_pie[i]   <= stk_pie[i-1];
            end
            stk_ret[0]   <= ret_next;
            stk_cause[0] <= cause_c;
            stk_pie[0]   <= ie_q;
            if (sp_q == SP_W'(NEST_DEPTH)) begin
                ovf_q <= 1'b1;
            end else begin
                sp_q <= sp_q + SP_W'(1);
            end
        end else if (iret_c) begin
            for (int i = 0; i < int'(NEST_DEPTH) - 1; i++) begin
                stk_ret[i]   <= stk_ret[i+1];
                stk_cause[i] <= stk_cause[i+1];
                stk_pie[i]   <= stk_pie[i+1];
            end
            stk_ret[NEST_DEPTH-1]   <= '0;
            stk_cause[NEST_DEPTH-1] <= '0;
            stk_pie[NEST_DEPTH-1]   <= 1'b0;
            if (sp_q != '0) begin
                sp_q <= sp_q - SP_W'(1);
            end
        end
    end

    assign exc_ret_addr_o = stk_ret[0];
    assign exc_cause_o    = stk_cause[0];
    assign exc_ovf_o      = ovf_q;
`else
    logic [ADDR_W-1:0]  ret_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               pie_q;
    logic               unused_depth;

    assign ret_pie_c    = pie_q;
    assign unused_depth = ^(32'(NEST_DEPTH));

    // Single-level save; a nested take overwrites it.
    always_ff @(posedge exc_clk_i or negedge exc_rst_n_i) begin
        if (!exc_rst_n_i) begin
            ret_q   <= '0;
            cause_q <= '0;
            pie_q   <= 1'b0;
        end else if (exc_take_o) begin
            ret_q   <= ret_next;
            cause_q <= cause_c;
            pie_q   <= ie_q;
        end
    end

    assign exc_ret_addr_o = ret_q;
    assign exc_cause_o    = cause_q;
    assign exc_ovf_o      = 1'b0;
`endif

    assign exc_ie_o      = ie_q;
    assign exc_pending_o = pending_q;

endmodule
